// File: rtl/mlp_layer_tm.sv
// Time-multiplexed fully-connected layer: NL MAC lanes sweep NN neurons in ceil(NN/NL) passes
// over one buffered input vector; results stream out one neuron per o_valid&o_ready beat.
module mlp_layer_tm #(
  parameter int NN             = 30,
  parameter int NL             = 8,
  parameter int numWeight      = 784,
  parameter int dataWidth      = 16,
  parameter int weightIntWidth = 4,
  parameter int layerNum       = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [31:0]                     cfg_layer,
  input  logic                            wt_wr_en,
  input  logic [$clog2(NN*numWeight)-1:0] wt_wr_addr,
  input  logic [dataWidth-1:0]            wt_wr_data,
  input  logic                            b_wr_en,
  input  logic [$clog2(NN)-1:0]           b_wr_addr,
  input  logic [dataWidth-1:0]            b_wr_data,
  output logic                            cfg_err,
  input  logic                            act_mode,
  input  logic                            x_valid,
  output logic                            x_ready,
  input  logic [dataWidth-1:0]            x_in,
  output logic                            o_valid,
  input  logic                            o_ready,
  output logic [dataWidth-1:0]            o_data,
  output logic [$clog2(NN)-1:0]           o_idx,
  output logic                            o_last,
  output logic                            busy
);
  localparam int FRAC  = dataWidth - weightIntWidth;
  localparam int DW    = dataWidth;
  localparam int AW    = $clog2(NN*numWeight);
  localparam int IW    = $clog2(NN);
  localparam int XIW   = (numWeight > 1) ? $clog2(numWeight) : 1;
  localparam int KW    = $clog2(numWeight + 1);
  localparam int NPASS = (NN + NL - 1) / NL;
  localparam int PW    = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam int LW    = (NL > 1) ? $clog2(NL) : 1;
  localparam int PRW   = 2 * DW;
  localparam int ACCW  = 2 * DW + $clog2(numWeight);
  localparam int SUMW  = ACCW + 1;
  localparam logic signed [SUMW-1:0] SAT_MAX = SUMW'((64'(1) << (DW - 1)) - 64'(1));
  localparam logic signed [SUMW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_FINAL, S_EMIT} state_t;

  state_t                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [PW-1:0]           pass_q, pass_d;
  logic [LW-1:0]           emit_q, emit_d, sel;
  logic                    rd_vld_q, rd_vld_d;
  logic                    act_q, act_d;
  logic signed [DW-1:0]    xr_q, xr_d;
  logic signed [DW-1:0]    wr_q [NL];
  logic signed [DW-1:0]    wr_d [NL];
  logic signed [ACCW-1:0]  acc_q [NL];
  logic signed [ACCW-1:0]  acc_d [NL];
  logic signed [DW-1:0]    res_q [NL];
  logic signed [DW-1:0]    res_d [NL];
  logic signed [PRW-1:0]   prod [NL];
  logic                    o_valid_q, o_valid_d, o_last_q, o_last_d, cfg_err_q, cfg_err_d;
  logic [DW-1:0]           o_data_q, o_data_d;
  logic [IW-1:0]           o_idx_q, o_idx_d;
  logic                    cfg_match, wt_we, b_we, load;
  int                      rem, last_lane, n_sel;

  logic signed [DW-1:0]    wmem  [NN*numWeight];
  logic signed [DW-1:0]    bmem  [NN];
  logic signed [DW-1:0]    x_buf [numWeight];

  function automatic int nidx(input logic [PW-1:0] p, input int l);
    return int'(p) * NL + l;
  endfunction

  // bias align, floor shift back to Q format, saturate, then optional ReLU
  function automatic logic signed [DW-1:0] finalise(input logic signed [ACCW-1:0] acc,
                                                    input logic signed [DW-1:0]   bias,
                                                    input logic                   relu);
    logic signed [SUMW-1:0] sum;
    logic signed [SUMW-1:0] r;
    logic signed [DW-1:0]   y;
    sum = SUMW'(acc) + (SUMW'(bias) <<< FRAC);
    r   = sum >>> FRAC;
    if (r > SAT_MAX)      y = DW'(SAT_MAX);
    else if (r < SAT_MIN) y = DW'(SAT_MIN);
    else                  y = DW'(r);
    if (relu && y[DW-1]) y = '0;
    return y;
  endfunction

  assign cfg_match = (cfg_layer == 32'(layerNum));
  assign wt_we     = cfg_match && wt_wr_en && (state_q == S_IDLE) && (int'(wt_wr_addr) < NN*numWeight);
  assign b_we      = cfg_match && b_wr_en && (state_q == S_IDLE) && (int'(b_wr_addr) < NN);

  always_ff @(posedge clk) begin
    if (wt_we) wmem[wt_wr_addr] <= wt_wr_data;
    if (b_we)  bmem[b_wr_addr]  <= b_wr_data;
    if (x_valid && state_q == S_IDLE) x_buf[XIW'(k_q)] <= x_in;
  end

  always_comb begin
    for (int l = 0; l < NL; l++) prod[l] = PRW'(xr_q) * PRW'(wr_q[l]);
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    pass_d    = pass_q;
    emit_d    = emit_q;
    rd_vld_d  = 1'b0;
    act_d     = act_q;
    xr_d      = xr_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_idx_d   = o_idx_q;
    o_last_d  = o_last_q;
    cfg_err_d = cfg_match && (wt_wr_en || b_wr_en) && (state_q != S_IDLE);
    for (int l = 0; l < NL; l++) begin
      wr_d[l]  = wr_q[l];
      acc_d[l] = acc_q[l];
      res_d[l] = res_q[l];
    end
    rem       = NN - int'(pass_q) * NL;
    last_lane = (rem >= NL) ? NL - 1 : rem - 1;
    sel       = emit_q;
    load      = 1'b0;
    n_sel     = 0;

    case (state_q)
      S_IDLE: begin
        if (x_valid) begin
          if (int'(k_q) == numWeight - 1) begin
            state_d = S_COMPUTE;
            k_d     = '0;
            pass_d  = '0;
            act_d   = act_mode;
            for (int l = 0; l < NL; l++) acc_d[l] = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      S_COMPUTE: begin
        if (rd_vld_q) begin
          for (int l = 0; l < NL; l++) acc_d[l] = acc_q[l] + ACCW'(prod[l]);
        end
        if (int'(k_q) < numWeight) begin
          k_d      = k_q + KW'(1);
          rd_vld_d = 1'b1;
          xr_d     = x_buf[XIW'(k_q)];
          // lanes past the last neuron read zero so they accumulate nothing
          for (int l = 0; l < NL; l++)
            wr_d[l] = (nidx(pass_q, l) < NN) ?
                      wmem[AW'(nidx(pass_q, l) * numWeight + int'(k_q))] : '0;
        end else begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        for (int l = 0; l < NL; l++)
          res_d[l] = finalise(acc_q[l], (nidx(pass_q, l) < NN) ? bmem[IW'(nidx(pass_q, l))] : '0,
                              !act_q);
        emit_d  = '0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (o_valid_q && o_ready) begin
          if (int'(emit_q) == last_lane) begin
            o_valid_d = 1'b0;
            k_d       = '0;
            if (int'(o_idx_q) == NN - 1) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_COMPUTE;
              pass_d  = pass_q + PW'(1);
              for (int l = 0; l < NL; l++) acc_d[l] = '0;
            end
          end else begin
            sel    = emit_q + LW'(1);
            emit_d = sel;
            load   = 1'b1;
          end
        end else if (!o_valid_q) begin
          load = 1'b1;
        end
        if (load) begin
          n_sel     = nidx(pass_q, int'(sel));
          o_valid_d = 1'b1;
          o_data_d  = res_q[sel];
          o_idx_d   = IW'(n_sel);
          o_last_d  = (n_sel == NN - 1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      pass_q    <= '0;
      emit_q    <= '0;
      rd_vld_q  <= 1'b0;
      act_q     <= 1'b0;
      xr_q      <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_idx_q   <= '0;
      o_last_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      for (int l = 0; l < NL; l++) begin
        wr_q[l]  <= '0;
        acc_q[l] <= '0;
        res_q[l] <= '0;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      pass_q    <= pass_d;
      emit_q    <= emit_d;
      rd_vld_q  <= rd_vld_d;
      act_q     <= act_d;
      xr_q      <= xr_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_idx_q   <= o_idx_d;
      o_last_q  <= o_last_d;
      cfg_err_q <= cfg_err_d;
      for (int l = 0; l < NL; l++) begin
        wr_q[l]  <= wr_d[l];
        acc_q[l] <= acc_d[l];
        res_q[l] <= res_d[l];
      end
    end
  end

  assign x_ready = (state_q == S_IDLE);
  assign busy    = (state_q != S_IDLE);
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_idx   = o_idx_q;
  assign o_last  = o_last_q;
  assign cfg_err = cfg_err_q;
endmodule

// File: tb/tb_mlp_layer_tm.sv
// Bench for mlp_layer_tm (NN=5, NL=2, numWeight=4, Q4.12): directed and random vectors against
// an arithmetic reference model, including stalls, config rejection and mid-operation reset.
module tb_mlp_layer_tm;
  localparam int NN = 5;
  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_layer;
  logic        wt_wr_en;
  logic [4:0]  wt_wr_addr;
  logic [15:0] wt_wr_data;
  logic        b_wr_en;
  logic [2:0]  b_wr_addr;
  logic [15:0] b_wr_data;
  logic        cfg_err, act_mode, x_valid, x_ready;
  logic [15:0] x_in;
  logic        o_valid, o_ready;
  logic [15:0] o_data;
  logic [2:0]  o_idx;
  logic        o_last, busy;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] wm [NN][NW];
  logic signed [15:0] bm [NN];
  logic signed [15:0] xv [NW];

  mlp_layer_tm #(.NN(5), .NL(2), .numWeight(4), .dataWidth(16), .weightIntWidth(4), .layerNum(2)) dut (
    .clk(clk), .rst(rst), .cfg_layer(cfg_layer),
    .wt_wr_en(wt_wr_en), .wt_wr_addr(wt_wr_addr), .wt_wr_data(wt_wr_data),
    .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
    .cfg_err(cfg_err), .act_mode(act_mode),
    .x_valid(x_valid), .x_ready(x_ready), .x_in(x_in),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_idx(o_idx), .o_last(o_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // neuron result in real-number terms: floor((sum x*w)/2^12 + b), clipped, ReLU in mode 0
  function automatic logic [15:0] model(input int n, input bit mode);
    longint acc;
    acc = longint'(bm[n]) * 4096;
    for (int k = 0; k < NW; k++) acc += longint'(wm[n][k]) * longint'(xv[k]);
    acc = acc >>> 12;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    if (mode == 1'b0 && acc < 0) acc = 0;
    return 16'(acc);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_w(input int layer, input int addr, input logic [15:0] d);
    cfg_layer = 32'(layer); wt_wr_addr = 5'(addr); wt_wr_data = d; wt_wr_en = 1'b1;
    @(negedge clk);
    wt_wr_en = 1'b0;
  endtask

  task automatic wr_b(input int layer, input int addr, input logic [15:0] d);
    cfg_layer = 32'(layer); b_wr_addr = 3'(addr); b_wr_data = d; b_wr_en = 1'b1;
    @(negedge clk);
    b_wr_en = 1'b0;
  endtask

  task automatic load_all();
    for (int n = 0; n < NN; n++)
      for (int k = 0; k < NW; k++) wr_w(2, n * NW + k, wm[n][k]);
    for (int n = 0; n < NN; n++) wr_b(2, n, bm[n]);
  endtask

  task automatic set_all(input logic [15:0] w, input logic [15:0] b);
    for (int n = 0; n < NN; n++) begin
      bm[n] = b;
      for (int k = 0; k < NW; k++) wm[n][k] = w;
    end
    load_all();
  endtask

  task automatic send_vec(input bit mode);
    int k, g;
    k = 0; g = 0;
    act_mode = mode;
    while (k < NW && g < 100) begin
      x_valid = 1'b1; x_in = xv[k];
      if (x_ready) k++;
      @(negedge clk);
      g++;
    end
    x_valid = 1'b0;
    check("x_accept", k, NW);
  endtask

  task automatic collect(input int first, input int cnt, input bit mode, input int stall);
    int g;
    for (int i = first; i < first + cnt; i++) begin
      g = 0;
      while (!o_valid && g < 40) begin @(negedge clk); g++; end
      check("o_valid", o_valid, 1);
      if (i == stall) begin
        o_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check("stall_valid", o_valid, 1);
          check("stall_data", o_data, model(i, mode));
          check("stall_idx", o_idx, i);
        end
        o_ready = 1'b1;
      end
      check("o_data", o_data, model(i, mode));
      check("o_idx", o_idx, i);
      check("o_last", o_last, 32'(i == NN - 1));
      @(negedge clk);
    end
  endtask

  task automatic run_vector(input bit mode, input int stall, input bit probe);
    int d;
    send_vec(mode);
    d = 0;
    while (!o_valid && d < 40) begin
      if (d == 0) check("busy_compute", busy, 1);
      if (probe) begin
        if (d == 0) begin
          check("cfg_err_pre", cfg_err, 0);
          cfg_layer = 32'd2; wt_wr_addr = 5'd0; wt_wr_data = 16'h7FFF; wt_wr_en = 1'b1;
        end
        if (d == 1) begin check("cfg_err_pulse", cfg_err, 1); wt_wr_en = 1'b0; end
        if (d == 2) check("cfg_err_clear", cfg_err, 0);
      end
      @(negedge clk);
      d++;
    end
    check("first_latency", d, 7);
    collect(0, NN, mode, stall);
    check("end_o_valid", o_valid, 0);
    check("end_busy", busy, 0);
  endtask

  task automatic rand_small();
    for (int n = 0; n < NN; n++) begin
      bm[n] = 16'($urandom_range(0, 8191)) - 16'd4096;
      for (int k = 0; k < NW; k++) wm[n][k] = 16'($urandom_range(0, 8191)) - 16'd4096;
    end
  endtask

  initial begin
    int vcnt;
    rst = 1'b1; cfg_layer = '0; wt_wr_en = 1'b0; wt_wr_addr = '0; wt_wr_data = '0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; act_mode = 1'b0;
    x_valid = 1'b0; x_in = '0; o_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_x_ready", x_ready, 1);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_o_idx", o_idx, 0);
    check("rst_o_last", o_last, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_err", cfg_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // unit weights and inputs: every neuron yields 4.0, with a stall on idx 1
    set_all(16'h1000, 16'h0000);
    for (int k = 0; k < NW; k++) xv[k] = 16'h1000;
    run_vector(1'b0, 1, 1'b0);

    // zero weights, bias -1.0
    set_all(16'h0000, 16'hF000);
    run_vector(1'b0, -1, 1'b0);
    run_vector(1'b1, -1, 1'b0);

    // saturation at both rails
    set_all(16'h7FFF, 16'h0000);
    for (int k = 0; k < NW; k++) xv[k] = 16'h7FFF;
    run_vector(1'b0, -1, 1'b0);
    for (int k = 0; k < NW; k++) xv[k] = 16'h8000;
    run_vector(1'b1, -1, 1'b0);

    // random weights/biases/inputs
    for (int r = 0; r < 4; r++) begin
      rand_small();
      load_all();
      for (int k = 0; k < NW; k++) xv[k] = (r == 3) ? 16'($urandom) : 16'($urandom_range(0, 16383)) - 16'd8192;
      run_vector(1'($urandom_range(0, 1)), int'($urandom_range(0, NN - 1)), 1'b0);
    end

    // foreign-layer writes and a write while busy must leave RAM untouched
    for (int k = 0; k < NW; k++) xv[k] = 16'h1000;
    wr_w(3, 0, wm[0][0] + 16'h0800);
    wr_b(3, 0, bm[0] + 16'h0800);
    run_vector(1'b1, -1, 1'b1);

    // reset during pass 1
    for (int k = 0; k < NW; k++) xv[k] = 16'($urandom_range(0, 16383)) - 16'd8192;
    send_vec(1'b1);
    collect(0, 2, 1'b1, -1);
    check("busy_pass1", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_o_valid", o_valid, 0);
    check("mid_rst_x_ready", x_ready, 1);
    vcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_valid) vcnt++;
    end
    check("mid_rst_quiet", vcnt, 0);
    for (int k = 0; k < NW; k++) xv[k] = 16'($urandom_range(0, 16383)) - 16'd8192;
    run_vector(1'b1, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
